// File: rtl/lpif_gearbox_pkg.sv
// Shared constants, LPIF beat field offsets and FSM state types for the
// asymmetric 2:1 LPIF gearbox.
package lpif_gearbox_pkg;

  localparam int unsigned LPIF_BEAT_W = 145;
  localparam int unsigned LPIF_WORD_W = 2 * LPIF_BEAT_W;

  localparam int unsigned LPIF_STATE_LSB     = 0;
  localparam int unsigned LPIF_PROTID_LSB    = 4;
  localparam int unsigned LPIF_DATA_LSB      = 6;
  localparam int unsigned LPIF_DVALID_BIT    = 134;
  localparam int unsigned LPIF_CRC_LSB       = 135;
  localparam int unsigned LPIF_CRC_VALID_BIT = 143;
  localparam int unsigned LPIF_VALID_BIT     = 144;

  typedef enum logic {
    TX_LO,
    TX_HI
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_EMPTY,
    RX_LO,
    RX_HI
  } rx_state_t;

endpackage

// File: rtl/lpif_asym2_rx_unpack.sv
// RX unpacker: splits one two-beat FIFO word into up to two LPIF beats and
// counts words whose lower beat is invalid while the upper beat is valid.
module lpif_asym2_rx_unpack
  import lpif_gearbox_pkg::*;
#(
  parameter int unsigned BEAT_W = LPIF_BEAT_W,
  parameter int unsigned WORD_W = LPIF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              word_vld_i,
  output logic              word_rdy_o,
  output logic [BEAT_W-1:0] beat_data_o,
  output logic              beat_vld_o,
  output logic [7:0]        align_err_cnt_o
);

  rx_state_t         state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              vld_q, vld_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept;
  logic              misaligned;

  // In RX_LO a pending upper beat blocks intake for exactly one cycle.
  assign word_rdy_o = (state_q != RX_LO) || !hold_q[WORD_W-1];
  assign accept     = word_vld_i && word_rdy_o;
  assign misaligned = !word_data_i[BEAT_W-1] && word_data_i[WORD_W-1];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    beat_d  = beat_q;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    if (accept && misaligned && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
    unique case (state_q)
      RX_EMPTY, RX_HI: begin
        if (accept) begin
          hold_d  = word_data_i;
          beat_d  = word_data_i[BEAT_W-1:0];
          vld_d   = 1'b1;
          state_d = RX_LO;
        end else begin
          state_d = RX_EMPTY;
        end
      end
      RX_LO: begin
        if (hold_q[WORD_W-1]) begin
          beat_d  = hold_q[WORD_W-1:BEAT_W];
          vld_d   = 1'b1;
          state_d = RX_HI;
        end else if (accept) begin
          hold_d  = word_data_i;
          beat_d  = word_data_i[BEAT_W-1:0];
          vld_d   = 1'b1;
          state_d = RX_LO;
        end else begin
          state_d = RX_EMPTY;
        end
      end
      default: state_d = RX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_EMPTY;
      hold_q  <= '0;
      beat_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign beat_data_o     = beat_q;
  assign beat_vld_o      = vld_q;
  assign align_err_cnt_o = cnt_q;

endmodule

// File: rtl/lpif_asym2_half_master_gearbox.sv
// Asymmetric 2:1 LPIF gearbox: packs pairs of full-rate TX beats into FIFO
// words and unpacks RX FIFO words back into beats.
module lpif_asym2_half_master_gearbox
  import lpif_gearbox_pkg::*;
#(
  parameter int unsigned BEAT_W = LPIF_BEAT_W,
  parameter int unsigned WORD_W = LPIF_WORD_W
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic [BEAT_W-1:0] tx_beat_data,
  input  logic              tx_beat_vld,
  input  logic              tx_flush,
  output logic [WORD_W-1:0] txfifo_upstream_data,
  output logic              txfifo_upstream_vld,
  input  logic [WORD_W-1:0] rxfifo_downstream_data,
  input  logic              rxfifo_downstream_vld,
  output logic              rxfifo_downstream_rdy,
  output logic [BEAT_W-1:0] rx_beat_data,
  output logic              rx_beat_vld,
  output logic [7:0]        rx_align_err_cnt
);

  localparam int unsigned PAD_W = WORD_W - BEAT_W;

  tx_state_t         tx_state_q, tx_state_d;
  logic [BEAT_W-1:0] lo_q, lo_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_vld_q, word_vld_d;

  always_comb begin
    tx_state_d = tx_state_q;
    lo_d       = lo_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    unique case (tx_state_q)
      TX_LO: begin
        if (tx_beat_vld && tx_flush) begin
          word_d     = {{PAD_W{1'b0}}, tx_beat_data};
          word_vld_d = 1'b1;
        end else if (tx_beat_vld) begin
          lo_d       = tx_beat_data;
          tx_state_d = TX_HI;
        end
      end
      TX_HI: begin
        // A beat always wins over a simultaneous flush.
        if (tx_beat_vld) begin
          word_d     = {tx_beat_data, lo_q};
          word_vld_d = 1'b1;
          tx_state_d = TX_LO;
        end else if (tx_flush) begin
          word_d     = {{PAD_W{1'b0}}, lo_q};
          word_vld_d = 1'b1;
          tx_state_d = TX_LO;
        end
      end
      default: tx_state_d = TX_LO;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_state_q <= TX_LO;
      lo_q       <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      lo_q       <= lo_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign txfifo_upstream_data = word_q;
  assign txfifo_upstream_vld  = word_vld_q;

  lpif_asym2_rx_unpack #(
    .BEAT_W(BEAT_W),
    .WORD_W(WORD_W)
  ) u_rx_unpack (
    .clk             (clk_wr),
    .rst_n           (rst_wr_n),
    .word_data_i     (rxfifo_downstream_data),
    .word_vld_i      (rxfifo_downstream_vld),
    .word_rdy_o      (rxfifo_downstream_rdy),
    .beat_data_o     (rx_beat_data),
    .beat_vld_o      (rx_beat_vld),
    .align_err_cnt_o (rx_align_err_cnt)
  );

endmodule

// File: tb/tb_lpif_asym2_half_master_gearbox.sv
// Scoreboard bench for the LPIF 2:1 gearbox: TX words and RX beats are
// predicted at drive time and compared by negedge monitors.
module tb_lpif_asym2_half_master_gearbox;

  logic         clk_wr;
  logic         rst_wr_n;
  logic [144:0] tx_beat_data;
  logic         tx_beat_vld;
  logic         tx_flush;
  logic [289:0] txfifo_upstream_data;
  logic         txfifo_upstream_vld;
  logic [289:0] rxfifo_downstream_data;
  logic         rxfifo_downstream_vld;
  logic         rxfifo_downstream_rdy;
  logic [144:0] rx_beat_data;
  logic         rx_beat_vld;
  logic [7:0]   rx_align_err_cnt;

  lpif_asym2_half_master_gearbox #(
    .BEAT_W(145),
    .WORD_W(290)
  ) dut (
    .clk_wr                 (clk_wr),
    .rst_wr_n               (rst_wr_n),
    .tx_beat_data           (tx_beat_data),
    .tx_beat_vld            (tx_beat_vld),
    .tx_flush               (tx_flush),
    .txfifo_upstream_data   (txfifo_upstream_data),
    .txfifo_upstream_vld    (txfifo_upstream_vld),
    .rxfifo_downstream_data (rxfifo_downstream_data),
    .rxfifo_downstream_vld  (rxfifo_downstream_vld),
    .rxfifo_downstream_rdy  (rxfifo_downstream_rdy),
    .rx_beat_data           (rx_beat_data),
    .rx_beat_vld            (rx_beat_vld),
    .rx_align_err_cnt       (rx_align_err_cnt)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int cnt_exp    = 0;

  logic [289:0] tx_exp_q[$];
  logic [144:0] rx_exp_q[$];
  int           tx_stamp_q[$];
  int           rx_stamp_q[$];
  logic [289:0] last_tx;
  logic [144:0] last_rx;

  always @(posedge clk_wr) cyc++;

  always @(negedge clk_wr) begin
    logic [289:0] ew;
    logic [144:0] eb;
    if (!rst_wr_n) begin
      last_tx = '0;
      last_rx = '0;
    end else begin
      assertions++;
      if (txfifo_upstream_vld) begin
        if (tx_exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected_word got=%h", txfifo_upstream_data);
        end else begin
          ew = tx_exp_q.pop_front();
          if (txfifo_upstream_data !== ew) begin
            failures++;
            $display("FAIL tx_word got=%h exp=%h", txfifo_upstream_data, ew);
          end
        end
        last_tx = txfifo_upstream_data;
        tx_stamp_q.push_back(cyc);
      end else if (txfifo_upstream_data !== last_tx) begin
        failures++;
        $display("FAIL tx_hold got=%h exp=%h", txfifo_upstream_data, last_tx);
      end
      assertions++;
      if (rx_beat_vld) begin
        if (rx_exp_q.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected_beat got=%h", rx_beat_data);
        end else begin
          eb = rx_exp_q.pop_front();
          if (rx_beat_data !== eb) begin
            failures++;
            $display("FAIL rx_beat got=%h exp=%h", rx_beat_data, eb);
          end
        end
        last_rx = rx_beat_data;
        rx_stamp_q.push_back(cyc);
      end else if (rx_beat_data !== last_rx) begin
        failures++;
        $display("FAIL rx_hold got=%h exp=%h", rx_beat_data, last_rx);
      end
    end
  end

  function automatic logic [144:0] rbeat();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[144:0];
  endfunction

  // Inputs change 1 time unit after a rising edge, captured at the next one.
  task automatic tx_drive(input logic [144:0] b, input logic v, input logic f);
    @(posedge clk_wr); #1;
    tx_beat_data = b;
    tx_beat_vld  = v;
    tx_flush     = f;
  endtask

  task automatic tx_idle();
    @(posedge clk_wr); #1;
    tx_beat_vld = 1'b0;
    tx_flush    = 1'b0;
  endtask

  task automatic send_rx_word(input logic [289:0] w, output int stalls);
    bit acc;
    acc    = 0;
    stalls = 0;
    rxfifo_downstream_data = w;
    rxfifo_downstream_vld  = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk_wr);
      if (rxfifo_downstream_rdy) begin
        acc = 1;
        rx_exp_q.push_back(w[144:0]);
        if (w[289]) rx_exp_q.push_back(w[289:145]);
        if (!w[144] && w[289] && cnt_exp < 255) cnt_exp++;
      end else begin
        stalls++;
      end
      @(posedge clk_wr); #1;
    end
    assertions++;
    if (!acc) begin
      failures++;
      $display("FAIL rx_accept_timeout got=rdy_low exp=accepted");
    end
  endtask

  task automatic rx_idle();
    rxfifo_downstream_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && n < 30) begin
      @(posedge clk_wr); #1;
      n++;
    end
    repeat (2) begin @(posedge clk_wr); #1; end
    assertions++;
    if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got=tx%0d/rx%0d pending exp=0", tag, tx_exp_q.size(), rx_exp_q.size());
      tx_exp_q.delete();
      rx_exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    assertions++;
    if (txfifo_upstream_data !== '0 || txfifo_upstream_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s_tx got=%h/%b exp=0/0", tag, txfifo_upstream_data, txfifo_upstream_vld);
    end
    assertions++;
    if (rx_beat_data !== '0 || rx_beat_vld !== 1'b0 || rx_align_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL %s_rx got=%h/%b/%0d exp=0/0/0", tag, rx_beat_data, rx_beat_vld, rx_align_err_cnt);
    end
    assertions++;
    if (rxfifo_downstream_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_rdy got=%b exp=1", tag, rxfifo_downstream_rdy);
    end
  endtask

  task automatic test_reset();
    rst_wr_n = 1'b0;
    tx_beat_data = '0; tx_beat_vld = 1'b0; tx_flush = 1'b0;
    rxfifo_downstream_data = '0; rxfifo_downstream_vld = 1'b0;
    repeat (3) @(posedge clk_wr);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    @(posedge clk_wr); #1;
  endtask

  task automatic test_tx_pairs();
    logic [144:0] b[4];
    foreach (b[i]) b[i] = rbeat();
    tx_stamp_q.delete();
    tx_exp_q.push_back({b[1], b[0]});
    tx_exp_q.push_back({b[3], b[2]});
    foreach (b[i]) tx_drive(b[i], 1'b1, 1'b0);
    tx_idle();
    wait_drain("tx_pairs");
    assertions++;
    if (tx_stamp_q.size() != 2 || tx_stamp_q[1] - tx_stamp_q[0] != 2) begin
      failures++;
      $display("FAIL tx_pair_spacing got=%0d words exp=2 words 2 cycles apart", tx_stamp_q.size());
    end
  endtask

  task automatic test_tx_flush();
    logic [144:0] a, e, f, g, h, i, j, k;
    a = rbeat(); e = rbeat(); f = rbeat(); g = rbeat();
    h = rbeat(); i = rbeat(); j = rbeat(); k = rbeat();
    tx_stamp_q.delete();
    // flush after a single beat, then a normal pair lands in the lower half
    tx_exp_q.push_back({145'h0, a});
    tx_exp_q.push_back({f, e});
    tx_drive(a, 1'b1, 1'b0);
    tx_drive('0, 1'b0, 1'b1);
    tx_drive(e, 1'b1, 1'b0);
    tx_drive(f, 1'b1, 1'b0);
    // flush with a beat in TX_LO, flush with a beat in TX_HI, flush alone in TX_LO
    tx_exp_q.push_back({145'h0, g});
    tx_exp_q.push_back({i, h});
    tx_drive(g, 1'b1, 1'b1);
    tx_drive(h, 1'b1, 1'b0);
    tx_drive(i, 1'b1, 1'b1);
    tx_drive('0, 1'b0, 1'b1);
    tx_exp_q.push_back({k, j});
    tx_drive(j, 1'b1, 1'b0);
    tx_drive(k, 1'b1, 1'b0);
    tx_idle();
    wait_drain("tx_flush");
    assertions++;
    if (tx_stamp_q.size() != 5) begin
      failures++;
      $display("FAIL tx_flush_strobes got=%0d exp=5", tx_stamp_q.size());
    end
  endtask

  task automatic test_rx_back_to_back();
    logic [289:0] w0, w1;
    int s0, s1;
    w0 = {rbeat(), rbeat()}; w0[289] = 1'b1; w0[144] = 1'b1;
    w1 = {rbeat(), rbeat()}; w1[289] = 1'b1; w1[144] = 1'b1;
    rx_stamp_q.delete();
    send_rx_word(w0, s0);
    send_rx_word(w1, s1);
    rx_idle();
    wait_drain("rx_b2b");
    assertions++;
    if (s0 != 0 || s1 != 1) begin
      failures++;
      $display("FAIL rx_b2b_stalls got=%0d/%0d exp=0/1", s0, s1);
    end
    assertions++;
    if (rx_stamp_q.size() != 4 || rx_stamp_q[3] - rx_stamp_q[0] != 3) begin
      failures++;
      $display("FAIL rx_b2b_timing got=%0d beats exp=4 consecutive", rx_stamp_q.size());
    end
  endtask

  task automatic test_rx_single_beat();
    logic [289:0] w0, w1;
    int s0, s1;
    w0 = {rbeat(), rbeat()}; w0[289] = 1'b0;
    w1 = {rbeat(), rbeat()}; w1[289] = 1'b0;
    rx_stamp_q.delete();
    send_rx_word(w0, s0);
    send_rx_word(w1, s1);
    rx_idle();
    wait_drain("rx_single");
    assertions++;
    if (s0 != 0 || s1 != 0) begin
      failures++;
      $display("FAIL rx_single_stalls got=%0d/%0d exp=0/0", s0, s1);
    end
    assertions++;
    if (rx_stamp_q.size() != 2 || rx_stamp_q[1] - rx_stamp_q[0] != 1) begin
      failures++;
      $display("FAIL rx_single_timing got=%0d beats exp=2 consecutive", rx_stamp_q.size());
    end
  endtask

  task automatic test_align_err();
    logic [289:0] w;
    int s;
    assertions++;
    if (rx_align_err_cnt !== 8'(cnt_exp)) begin
      failures++;
      $display("FAIL align_cnt_start got=%0d exp=%0d", rx_align_err_cnt, cnt_exp);
    end
    for (int n = 0; n < 300; n++) begin
      w = {rbeat(), rbeat()}; w[144] = 1'b0; w[289] = 1'b1;
      send_rx_word(w, s);
      if (n == 99) begin
        @(posedge clk_wr); #1;
        assertions++;
        if (rx_align_err_cnt !== 8'(cnt_exp)) begin
          failures++;
          $display("FAIL align_cnt_100 got=%0d exp=%0d", rx_align_err_cnt, cnt_exp);
        end
      end
    end
    rx_idle();
    wait_drain("align");
    assertions++;
    if (rx_align_err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL align_cnt_sat got=%0d exp=255", rx_align_err_cnt);
    end
    for (int n = 0; n < 5; n++) begin
      w = {rbeat(), rbeat()}; w[144] = 1'b0; w[289] = 1'b1;
      send_rx_word(w, s);
    end
    rx_idle();
    wait_drain("align_hold");
    assertions++;
    if (rx_align_err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL align_cnt_stay got=%0d exp=255", rx_align_err_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [144:0] a, c, d;
    logic [289:0] w;
    int s;
    a = rbeat(); c = rbeat(); d = rbeat();
    w = {rbeat(), rbeat()}; w[289] = 1'b1; w[144] = 1'b1;
    tx_drive(a, 1'b1, 1'b0);
    tx_idle();
    send_rx_word(w, s);
    rx_idle();
    // TX holds a half word and RX sits in RX_LO; both are discarded
    rst_wr_n = 1'b0;
    cnt_exp = 0;
    rx_exp_q.delete();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk_wr);
    #1;
    check_reset_outputs("mid_reset_hold");
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    @(posedge clk_wr); #1;
    tx_exp_q.push_back({d, c});
    tx_drive(c, 1'b1, 1'b0);
    tx_drive(d, 1'b1, 1'b0);
    tx_idle();
    wait_drain("mid_reset");
  endtask

  initial begin
    test_reset();
    test_tx_pairs();
    test_tx_flush();
    test_rx_back_to_back();
    test_rx_single_beat();
    test_align_err();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lpif_asym2_half_master_gearbox.md
LPIF_ASYM2_HALF_MASTER_GEARBOX -- requirements
Module: lpif_asym2_half_master_gearbox

Interface
REQ-001 SHALL have parameters: BEAT_W, default 145, width of one LPIF beat; WORD_W, default 290 (2*BEAT_W), width of one logic-link FIFO word.
REQ-002 SHALL have ports: clk_wr  in  1  single clock, all logic rising-edge; rst_wr_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: tx_beat_data  in  145  full-rate LPIF beat (state[3:0]@0, protid[1:0]@4, data[127:0]@6, dvalid@134, crc[7:0]@135, crc_valid@143, valid@144); tx_beat_vld  in  1  beat present.
REQ-004 SHALL have ports: tx_flush  in  1  close a half-filled word; txfifo_upstream_data  out  290  packed word; txfifo_upstream_vld  out  1  one-cycle word strobe.
REQ-005 SHALL have ports: rxfifo_downstream_data  in  290  packed word; rxfifo_downstream_vld  in  1  word offered; rxfifo_downstream_rdy  out  1  word accepted when vld&rdy.
REQ-006 SHALL have ports: rx_beat_data  out  145  unpacked beat; rx_beat_vld  out  1  beat strobe; rx_align_err_cnt  out  8  saturating misalignment count.

Function
REQ-007 TX path SHALL be a two-state FSM, TX_LO and TX_HI; a beat in TX_LO is held in the lower holding register [144:0] and the FSM moves to TX_HI.
REQ-008 A beat in TX_HI SHALL complete the word (beat at [289:145]) and the FSM SHALL return to TX_LO; txfifo_upstream_data/vld SHALL be registered, with vld high exactly one cycle, the cycle after the completing beat.
REQ-009 tx_flush in TX_HI without a beat SHALL emit the held lower half with the upper 145 bits zero and return to TX_LO.
REQ-010 tx_flush together with a beat in TX_HI SHALL be ignored; the beat completes the word normally.
REQ-011 tx_flush together with a beat in TX_LO SHALL emit that beat in the lower half, upper half zero, and stay in TX_LO; tx_flush in TX_LO without a beat SHALL do nothing.
REQ-012 txfifo_upstream_data SHALL hold its last value while vld is low.
REQ-013 RX path SHALL be a three-state FSM: RX_EMPTY, RX_LO and RX_HI; an accepted word is stored in a 290-bit holding register.
REQ-014 rxfifo_downstream_rdy SHALL be high in RX_EMPTY and RX_HI; in RX_LO it SHALL be high only when held bit 289 is 0.
REQ-015 For a word accepted at cycle N, the lower beat SHALL appear at cycle N+1 with rx_beat_vld=1, and the FSM enters RX_LO.
REQ-016 From RX_LO, if held bit 289 is 1 the FSM SHALL go to RX_HI and emit the upper beat at N+2.
REQ-017 From RX_LO, if held bit 289 is 0 the upper beat SHALL be dropped; the FSM SHALL go to RX_LO (new word accepted) or RX_EMPTY (no new word).
REQ-018 From RX_HI, an accepted word SHALL go to RX_LO and emit without a bubble; otherwise the FSM SHALL go to RX_EMPTY.
REQ-019 An accepted word with bit 144 = 0 and bit 289 = 1 SHALL increment rx_align_err_cnt, saturating at 255; the beats SHALL still be forwarded per REQ-015..018.
REQ-020 rx_beat_data SHALL hold its last value while rx_beat_vld is low.

Reset
REQ-021 Asserting rst_wr_n low SHALL immediately force TX_LO and RX_EMPTY, and clear all holding registers, txfifo_upstream_data, txfifo_upstream_vld, rx_beat_data, rx_beat_vld and rx_align_err_cnt to 0.
REQ-022 rxfifo_downstream_rdy SHALL be 1 during reset; a half-filled TX word or half-emitted RX word SHALL be discarded without any strobe.

Structure
REQ-023 A shared package lpif_gearbox_pkg SHALL hold the BEAT_W/WORD_W constants, the beat field offsets, and the tx_state_t and rx_state_t enums.
REQ-024 The RX unpacker SHALL be a sub-module, lpif_asym2_rx_unpack; the TX packer SHALL stay in the top module.

Verification
REQ-025 Beats A, B on consecutive cycles -> one cycle later txfifo_upstream_vld=1 and txfifo_upstream_data={B,A}; the next pair gives no gap.
REQ-026 Beat A then tx_flush alone -> word {145'h0,A} with a single strobe; FSM is back in TX_LO (next beat goes to the lower half).
REQ-027 Back-to-back RX words W0, W1 with bit 289=1 -> rx beats W0lo, W0hi, W1lo, W1hi on 4 consecutive cycles; rdy is low in each RX_LO cycle.
REQ-028 RX word with bit 289=0 followed by another word -> only the lower beat is emitted, the next word is accepted in RX_LO, and there is no bubble.
REQ-029 300 words with bit144=0 and bit289=1 -> rx_align_err_cnt=255 and stays at 255.
REQ-030 rst_wr_n pulled low while in TX_HI and RX_LO -> all outputs 0 and rdy=1; after release, beat C, D -> word {D,C}.
